// File: rtl/mult_div_unit.sv
// Sequential multiply / divide unit: shift-add multiply and restoring divide, one bit per cycle,
// with hi/lo result registers that can also be loaded directly while idle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              b_zero_q, b_zero_d;
  logic [WIDTH-1:0]  srca_q, srca_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  lsr_q, lsr_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    a_neg = op_sign & srca[WIDTH-1];
    b_neg = op_sign & srcb[WIDTH-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;

    // Multiply: {acc, lsr} is the running product, lsr also shifts out multiplier bits.
    mul_sum  = {1'b0, acc_q} + {1'b0, (lsr_q[0] ? opnd_q : '0)};
    // Divide: acc is the partial remainder, lsr shifts dividend out and quotient in.
    div_shift = {acc_q, lsr_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = {acc_q, lsr_q};
    prod_neg  = -prod;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    srca_d   = srca_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    lsr_d    = lsr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          state_d  = StCalc;
          cnt_d    = '0;
          div_d    = op_div;
          neg_a_d  = a_neg;
          neg_b_d  = b_neg;
          b_zero_d = (srcb == '0);
          srca_d   = srca;
          acc_d    = '0;
          opnd_d   = op_div ? b_mag : a_mag;
          lsr_d    = op_div ? a_mag : b_mag;
        end
      end
      StCalc: begin
        if (div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            lsr_d = {lsr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            lsr_d = {lsr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[WIDTH:1];
          lsr_d = {mul_sum[0], lsr_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StSign;
      end
      StSign: begin
        if (div_q) begin
          if (b_zero_q) begin
            hi_d  = srca_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? -lsr_q : lsr_q;
            hi_d = neg_a_q ? -acc_q : acc_q;
          end
        end else begin
          {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      srca_q   <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      lsr_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      srca_q   <= srca_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      lsr_q    <= lsr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit (WIDTH=32) against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op_div;
  logic         op_sign;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc, busy_cnt, done_cnt;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .op_sign     (op_sign),
    .srca        (srca),
    .srcb        (srcb),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  task automatic model(input logic d, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    edz = 1'b0;
    if (!d) begin
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh  = a;
      el  = '1;
      edz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      el = 32'(q);
      eh = 32'(r);
    end else begin
      el = a / b;
      eh = a % b;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic start_op(input logic d, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    op_div  = d;
    op_sign = s;
    srca    = a;
    srcb    = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    cyc      = 0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edz);
    while (!done && cyc < 60) step();
    check({tag, ".latency"}, 64'(cyc), 64'd33);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, ".hi"}, 64'(hi), 64'(eh));
    check({tag, ".lo"}, 64'(lo), 64'(el));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(edz));
  endtask

  task automatic after_done(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    step();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".dbz_pulse"}, 64'(div_by_zero), 64'd0);
    check({tag, ".hi_hold"}, 64'(hi), 64'(eh));
    check({tag, ".lo_hold"}, 64'(lo), 64'(el));
  endtask

  task automatic run_check(input string tag, input logic d, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic         edz;
    model(d, s, a, b, eh, el, edz);
    start_op(d, s, a, b);
    wait_done(tag, eh, el, edz);
    after_done(tag, eh, el);
  endtask

  initial begin
    logic [W-1:0] eh, el, eh2, el2, a, b, hold;
    logic         edz, d, s;
    int           r;

    reset   = 1'b1;
    start   = 1'b0;
    op_div  = 1'b0;
    op_sign = 1'b0;
    srca    = '0;
    srcb    = '0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.dbz", 64'(div_by_zero), 64'd0);

    // Directed corner values with hand-derived results.
    start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("umul_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    after_done("umul_max", 32'hFFFF_FFFE, 32'h0000_0001);
    start_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done("smul_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("sdiv_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    start_op(1'b1, 1'b0, 32'd100, 32'd7);
    wait_done("udiv_100d7", 32'd2, 32'd14, 1'b0);
    start_op(1'b1, 1'b0, 32'h1234_5678, 32'd0);
    wait_done("div_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    after_done("div_zero", 32'h1234_5678, 32'hFFFF_FFFF);
    start_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("sdiv_ovf", 32'd0, 32'h8000_0000, 1'b0);
    after_done("sdiv_ovf", 32'd0, 32'h8000_0000);

    // Random operations, biased toward corner operands.
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) b = '0;
      if (r == 1) begin
        a = 32'h8000_0000;
        b = '1;
      end
      if (r == 2) b = 32'($urandom_range(1, 15));
      if (r == 3) a = 32'($urandom_range(0, 255));
      run_check("rand", d, s, a, b);
    end

    // start and wr_hi while busy are ignored; operands changed after start have no effect.
    model(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, edz);
    hold = hi;
    start_op(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) step();
    check("busy_ign.hi_calc", 64'(hi), 64'(hold));
    step();
    start   = 1'b1;
    op_div  = 1'b1;
    op_sign = 1'b1;
    srca    = 32'h0000_0123;
    srcb    = 32'h0000_0007;
    wr_hi   = 1'b1;
    wdata   = 32'hCAFE_F00D;
    step();
    start = 1'b0;
    wr_hi = 1'b0;
    check("busy_ign.hi_wr", 64'(hi), 64'(hold));
    wait_done("busy_ign", eh, el, 1'b0);
    repeat (40) step();
    check("busy_ign.done_count", 64'(done_cnt), 64'd1);
    check("busy_ign.hi_final", 64'(hi), 64'(eh));
    check("busy_ign.idle", 64'(busy), 64'd0);

    // Back-to-back: second start issued in the done cycle.
    model(1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_1234, eh, el, edz);
    model(1'b1, 1'b1, 32'h7654_3210, 32'hFFFF_FFF3, eh2, el2, edz);
    start_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_1234);
    wait_done("b2b_first", eh, el, 1'b0);
    start_op(1'b1, 1'b1, 32'h7654_3210, 32'hFFFF_FFF3);
    check("b2b.busy", 64'(busy), 64'd1);
    wait_done("b2b_second", eh2, el2, 1'b0);
    after_done("b2b_second", eh2, el2);

    // Direct load of lo only.
    hold  = hi;
    wr_lo = 1'b1;
    wdata = 32'hDEAD_BEEF;
    step();
    wr_lo = 1'b0;
    check("wr_lo.lo", 64'(lo), 64'hDEAD_BEEF);
    check("wr_lo.hi", 64'(hi), 64'(hold));

    // Both loads coincide with start: loads land now, the product overwrites them later.
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'h5555_AAAA;
    start_op(1'b0, 1'b0, 32'd7, 32'd9);
    check("ld_start.hi", 64'(hi), 64'h5555_AAAA);
    check("ld_start.lo", 64'(lo), 64'h5555_AAAA);
    check("ld_start.busy", 64'(busy), 64'd1);
    wait_done("ld_start", 32'd0, 32'd63, 1'b0);

    // Reset at cycle 10 of a divide aborts it.
    step();
    start_op(1'b1, 1'b0, 32'hABCD_0123, 32'd3);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.hi", 64'(hi), 64'd0);
    check("rst_mid.lo", 64'(lo), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    repeat (40) step();
    check("rst_mid.no_done", 64'(done_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets operand and result width; the unit SHALL support any WIDTH >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge.
REQ-005 op_div  input  1  operation select: 0 = multiply, 1 = divide.
REQ-006 op_sign  input  1  operand interpretation: 1 = two's-complement signed, 0 = unsigned.
REQ-007 srca  input  WIDTH  multiplicand or dividend.
REQ-008 srcb  input  WIDTH  multiplier or divisor.
REQ-009 wr_hi / wr_lo  input  1 each  direct-load strobes for hi / lo.
REQ-010 wdata  input  WIDTH  direct-load data.
REQ-011 hi  output  WIDTH  product upper half, or remainder.
REQ-012 lo  output  WIDTH  product lower half, or quotient.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 div_by_zero  output  1  set with done when a divide had srcb == 0.

Function
REQ-016 FSM states: IDLE, CALC, SIGN. busy SHALL be 1 whenever the state is not IDLE.
REQ-017 IDLE transitions:
- IDLE with start=1 at edge k: latch op_div, op_sign, |srca| and |srcb| (magnitudes when signed), plus the operand signs; go to CALC with iteration count 0.
- IDLE with start=0: stay in IDLE.
REQ-018 CALC performs one iteration per edge:
- multiply: shift-add, one multiplier bit per edge;
- divide: restoring shift-subtract, one quotient bit per edge.
After exactly WIDTH iterations (edges k+1..k+WIDTH), go to SIGN.
REQ-019 SIGN, at edge k+WIDTH+1:
- apply sign correction;
- write hi/lo;
- set done=1 for exactly one cycle;
- go to IDLE.
Result latency is WIDTH+1 cycles from the start edge, identical for all operations.
REQ-020 Multiply results: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH-bit product. Signed: negate the 2*WIDTH-bit product when the operand signs differ.
REQ-021 Divide results: lo = quotient, hi = remainder. Signed:
- quotient negative when the operand signs differ;
- remainder takes the sign of the dividend (truncation toward zero).
REQ-022 Signed most-negative / -1: lo SHALL equal the most-negative value and hi SHALL equal 0; no flag is raised.
REQ-023 Divide with srcb == 0: full latency still applies; then hi = original srca, lo = all ones, div_by_zero = 1 for the done cycle only.
REQ-024 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-025 start in the cycle done is high SHALL be accepted, since the state is IDLE.
REQ-026 Direct loads apply only in IDLE: wr_hi loads hi from wdata and wr_lo loads lo from wdata on the edge. When both strobes are set, both registers load.
REQ-027 wr_hi/wr_lo while busy SHALL be ignored.
REQ-028 If start and a direct-load strobe coincide in IDLE, the load SHALL take effect and the operation SHALL start; its result later overwrites hi/lo.
REQ-029 hi/lo SHALL hold their value from completion or load until the next completion or load; they SHALL NOT change during CALC.
REQ-030 srca, srcb, op_div and op_sign SHALL only be sampled at the start edge; later changes have no effect.

Reset
REQ-031 When reset=1 at an edge: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, iteration count = 0.
REQ-032 Reset mid-operation SHALL abort the operation with no done pulse; reset SHALL take priority over start and the load strobes.

Verification (WIDTH=32)
REQ-033 Unsigned multiply 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
REQ-034 Signed multiply -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed divide -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned 100/7 -> lo=14, hi=2.
REQ-035 Divide 0x12345678/0 -> done after 33 cycles, hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1 for one cycle; signed 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-036 Assert start at cycle 5 of a busy multiply with different operands, and pulse wr_hi mid-operation -> the original result is unaffected and exactly one done pulse occurs.
REQ-037 Assert start again in the done cycle -> the second result is valid 33 cycles later; wr_lo=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle, hi unchanged.
REQ-038 Assert reset at cycle 10 of a divide -> next cycle busy=0, hi=lo=0, and no done pulse follows.
